// File: rtl/dense_mac_if.sv
// Handshake and tensor-access bundle for the dense_mac dot-product engine.
// The master side is the requester plus the hidden/weight tensor storage.
interface dense_mac_if;
   logic        start;
   logic        act;
   logic [15:0] bias;
   logic [3:0]  h_sel;
   logic [15:0] h_val;
   logic [3:0]  w_sel;
   logic [15:0] w_val;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        ovf;

   modport master (
      output start, act, bias, h_val, w_val,
      input  h_sel, w_sel, busy, done, result, ovf
   );

   modport slave (
      input  start, act, bias, h_val, w_val,
      output h_sel, w_sel, busy, done, result, ovf
   );
endinterface

// File: rtl/dense_mac.sv
// 16-element Q8.8 dot product with bias, saturation and optional ReLU.
// Tensor reads have one cycle of latency, so products trail the index by one cycle.
module dense_mac (
   input logic         clk,
   input logic         rst_n,
   dense_mac_if.slave  bus
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] RUN   = 3'd1;
   localparam logic [2:0] DRAIN = 3'd2;
   localparam logic [2:0] FINAL = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   logic [2:0]         state;
   logic [3:0]         idx;
   logic signed [35:0] acc;
   logic               act_q;
   logic [15:0]        bias_q;
   logic [15:0]        result_q;
   logic               ovf_q;

   logic signed [31:0] product;
   logic               accumulate;
   logic signed [36:0] sum;
   logic signed [36:0] shifted;
   logic [15:0]        sat_val;
   logic               sat_ovf;
   logic [15:0]        final_val;

   assign product    = $signed(bus.h_val) * $signed(bus.w_val);
   // The first RUN cycle still sees stale tensor data; DRAIN picks up element 15.
   assign accumulate = ((state == RUN) && (idx != 4'd0)) || (state == DRAIN);

   assign sum     = {acc[35], acc} + {{13{bias_q[15]}}, bias_q, 8'b0};
   assign shifted = sum >>> 8;

   always_comb begin
      sat_val = shifted[15:0];
      sat_ovf = 1'b0;
      if (shifted > 37'sd32767) begin
         sat_val = 16'h7FFF;
         sat_ovf = 1'b1;
      end else if (shifted < -37'sd32768) begin
         sat_val = 16'h8000;
         sat_ovf = 1'b1;
      end
      final_val = (act_q && sat_val[15]) ? 16'h0000 : sat_val;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= 4'd0;
         acc      <= '0;
         act_q    <= 1'b0;
         bias_q   <= 16'h0000;
         result_q <= 16'h0000;
         ovf_q    <= 1'b0;
      end else begin
         if (accumulate)
            acc <= acc + {{4{product[31]}}, product};
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state  <= RUN;
                  idx    <= 4'd0;
                  acc    <= '0;
                  act_q  <= bus.act;
                  bias_q <= bus.bias;
               end
            end
            RUN: begin
               idx <= idx + 4'd1;
               if (idx == 4'd15)
                  state <= DRAIN;
            end
            DRAIN: state <= FINAL;
            FINAL: begin
               result_q <= final_val;
               ovf_q    <= sat_ovf;
               state    <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.h_sel  = (state == RUN) ? idx : 4'd0;
   assign bus.w_sel  = (state == RUN) ? idx : 4'd0;
   assign bus.busy   = (state != IDLE);
   assign bus.done   = (state == DONE);
   assign bus.result = result_q;
   assign bus.ovf    = ovf_q;

endmodule
